// File: rtl/rocc_accum_pkg.sv
// Shared opcodes and cache-port constants for the RoCC accumulator bank.
package rocc_accum_pkg;

    typedef enum logic [6:0] {
        FN_WRITE = 7'd0,
        FN_READ  = 7'd1,
        FN_LOAD  = 7'd2,
        FN_ACCUM = 7'd3,
        FN_STORE = 7'd4,
        FN_CLEAR = 7'd5
    } funct_e;

    localparam logic [4:0] M_XRD = 5'd0;
    localparam logic [4:0] M_XWR = 5'd1;
    localparam logic [2:0] MT_D  = 3'd3;

endpackage

// File: rtl/accum_alu.sv
// Combinational accumulate adder: wraps mod 2^XLEN, or clamps on signed overflow.
module accum_alu #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned SATURATE = 0
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum
);

    logic [XLEN-1:0] raw;
    logic            ovf;

    always_comb begin
        raw = a + b;
        // Signed overflow: operands share a sign that the result does not.
        ovf = (a[XLEN-1] == b[XLEN-1]) && (raw[XLEN-1] != a[XLEN-1]);
        sum = raw;
        if (SATURATE != 0 && ovf) begin
            sum = a[XLEN-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
        end
    end

endmodule

// File: rtl/rocc_accum_bank.sv
// RoCC accumulator bank: one-entry command register, register file, load scoreboard
// and L1 cache request/response handling.
module rocc_accum_bank
    import rocc_accum_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned PADDR_W  = 40,
    parameter int unsigned TAG_W    = 10,
    parameter int unsigned SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [6:0]         cmd_funct,
    input  logic               cmd_xd,
    input  logic [4:0]         cmd_rd,
    input  logic [XLEN-1:0]    cmd_rs1,
    input  logic [XLEN-1:0]    cmd_rs2,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [4:0]         resp_rd,
    output logic [XLEN-1:0]    resp_data,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [PADDR_W-1:0] mem_req_addr,
    output logic [TAG_W-1:0]   mem_req_tag,
    output logic [4:0]         mem_req_cmd,
    output logic [2:0]         mem_req_typ,
    output logic [XLEN-1:0]    mem_req_data,
    input  logic               mem_resp_valid,
    input  logic [TAG_W-1:0]   mem_resp_tag,
    input  logic               mem_resp_has_data,
    input  logic [XLEN-1:0]    mem_resp_data,
    output logic               busy,
    output logic               interrupt
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic              valid_q, valid_d;
    logic [6:0]        funct_q;
    logic              xd_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   rs1_q;
    logic [IDX_W-1:0]  idx_q;

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_sb_q, busy_sb_d;

    logic             is_mem, stall_reg, stall_resp, stall_mem, retire, cmd_fire;
    logic             load_done;
    logic [IDX_W-1:0] resp_idx;
    logic [XLEN-1:0]  cur_val, acc_sum;
    logic             unused_bits;

    assign unused_bits = ^{cmd_rs2[XLEN-1:IDX_W], mem_resp_tag[TAG_W-1:IDX_W+1]};

    assign cur_val = regs_q[idx_q];
    assign is_mem  = (funct_q == FN_LOAD) || (funct_q == FN_STORE);

    always_comb begin
        case (funct_q)
            FN_WRITE, FN_READ, FN_LOAD, FN_ACCUM, FN_STORE: stall_reg = busy_sb_q[idx_q];
            FN_CLEAR: stall_reg = |busy_sb_q;
            default:  stall_reg = 1'b0;
        endcase
    end

    assign stall_resp = xd_q & ~resp_ready;
    assign stall_mem  = is_mem & ~mem_req_ready;
    assign retire     = valid_q & ~stall_reg & ~stall_resp & ~stall_mem;
    assign cmd_ready  = ~valid_q | retire;
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign valid_d    = cmd_fire ? 1'b1 : (retire ? 1'b0 : valid_q);

    assign resp_valid = valid_q & xd_q & ~stall_reg & ~stall_mem;
    assign resp_rd    = rd_q;
    assign resp_data  = cur_val;

    assign mem_req_valid = valid_q & is_mem & ~stall_reg & ~stall_resp;
    assign mem_req_addr  = rs1_q[PADDR_W-1:0];
    assign mem_req_cmd   = (funct_q == FN_STORE) ? M_XWR : M_XRD;
    assign mem_req_typ   = MT_D;
    assign mem_req_data  = cur_val;

    always_comb begin
        mem_req_tag            = '0;
        mem_req_tag[IDX_W:0]   = {funct_q == FN_STORE, idx_q};
    end

    assign busy      = valid_q | (|busy_sb_q);
    assign interrupt = 1'b0;

    // Store acks carry the is_store tag bit or no data and never touch the bank.
    assign load_done = mem_resp_valid & mem_resp_has_data & ~mem_resp_tag[IDX_W];
    assign resp_idx  = mem_resp_tag[IDX_W-1:0];

    accum_alu #(
        .XLEN     (XLEN),
        .SATURATE (SATURATE)
    ) u_alu (
        .a   (cur_val),
        .b   (rs1_q),
        .sum (acc_sum)
    );

    always_comb begin
        regs_d    = regs_q;
        busy_sb_d = busy_sb_q;
        if (load_done) begin
            regs_d[resp_idx]    = mem_resp_data;
            busy_sb_d[resp_idx] = 1'b0;
        end
        if (retire) begin
            case (funct_q)
                FN_WRITE: regs_d[idx_q] = rs1_q;
                FN_ACCUM: regs_d[idx_q] = acc_sum;
                FN_LOAD:  busy_sb_d[idx_q] = 1'b1;
                FN_CLEAR: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        regs_d[i] = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            funct_q   <= '0;
            xd_q      <= 1'b0;
            rd_q      <= '0;
            rs1_q     <= '0;
            idx_q     <= '0;
            busy_sb_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            busy_sb_q <= busy_sb_d;
            regs_q    <= regs_d;
            if (cmd_fire) begin
                funct_q <= cmd_funct;
                xd_q    <= cmd_xd;
                rd_q    <= cmd_rd;
                rs1_q   <= cmd_rs1;
                idx_q   <= cmd_rs2[IDX_W-1:0];
            end
        end
    end

endmodule

// File: doc/rocc_accum_bank.md
Name: rocc_accum_bank

Overview:
Parametrised RoCC accumulator bank: NUM_REGS XLEN-bit registers with command-driven write, read, accumulate, memory load, memory store and clear-all.
- Per-register scoreboard allows several loads outstanding at once.
- Optional signed-saturating accumulate mode.
- Sits between the core's RoCC cmd/resp ports and the L1 data-cache request/response port; generalises the 4-entry load/accumulate accelerator.

Parameters:
NUM_REGS, 8, number of accumulator registers (power of 2, >=2)
XLEN, 64, register and data width
PADDR_W, 40, memory address width
TAG_W, 10, memory tag width (>= log2(NUM_REGS)+1)
SATURATE, 0, 0 = accumulate wraps mod 2^XLEN; 1 = signed saturation

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_funct  in  7  opcode: 0 write, 1 read, 2 load, 3 accum, 4 store, 5 clear-all
cmd_xd  in  1  command returns a response
cmd_rd  in  5  destination core register
cmd_rs1  in  XLEN  data operand / memory address
cmd_rs2  in  XLEN  register index in low log2(NUM_REGS) bits
resp_valid  out  1  response valid
resp_ready  in  1  core accepts response
resp_rd  out  5  echo of cmd_rd
resp_data  out  XLEN  register value before the operation
mem_req_valid  out  1  cache request valid
mem_req_ready  in  1  cache accepts request
mem_req_addr  out  PADDR_W  rs1[PADDR_W-1:0]
mem_req_tag  out  TAG_W  {0.., is_store, idx}
mem_req_cmd  out  5  0 = load, 1 = store
mem_req_typ  out  3  constant 3 (doubleword)
mem_req_data  out  XLEN  store data = register value
mem_resp_valid  in  1  cache response
mem_resp_tag  in  TAG_W  returned tag
mem_resp_has_data  in  1  response carries load data
mem_resp_data  in  XLEN  load data
busy  out  1  held command, or any scoreboard bit set
interrupt  out  1  constant 0

Behaviour:
- One-entry command holding register (cmd_q, valid_q).
  - cmd_ready = !valid_q | retire.
  - Accept and retire in the same cycle is allowed; this gives back-to-back throughput of 1 command/cycle.
- idx = rs2[log2(NUM_REGS)-1:0]; upper bits are ignored.
- Stall conditions:
  - stall_reg = busy_sb[idx] for funct 0–4.
  - For funct 5, stall_reg = |busy_sb.
  - stall_resp = xd & !resp_ready.
  - stall_mem = (funct==2|4) & !mem_req_ready.
- retire = valid_q & !stall_reg & !stall_resp & !stall_mem.
- resp_valid = valid_q & xd & !stall_reg & !stall_mem.
- mem_req_valid = valid_q & (funct==2|4) & !stall_reg & !stall_resp.
- Effects, all at retire:
  - write: reg[idx] <= rs1.
  - accum: reg[idx] <= reg[idx] + rs1.
    - SATURATE=1: signed overflow clamps to 2^(XLEN-1)-1 or -2^(XLEN-1).
  - load: busy_sb[idx] <= 1.
  - store: no register change.
  - clear-all: every reg <= 0.
  - read: no side effect.
  - Undefined funct: retires as a no-op, and responds if xd.
- Load completion: mem_resp_valid & has_data & !tag[log2(NUM_REGS)] sets reg[tag idx] <= data and clears busy_sb[tag idx].
  - Store acks (is_store tag bit set, or has_data=0) are ignored.
- Simultaneous events:
  - A load response and a retiring command for a different idx both take effect.
  - The same idx cannot collide, because the busy bit stalls the command.
  - A response clearing bit i while a load sets bit j!=i: both apply.
- Response latency: combinational from cmd_q. resp_data is the pre-operation value.
- Reset (async, any time, including mid-load):
  - valid_q = 0, busy_sb = 0, all regs = 0.
  - Outputs resp_valid = mem_req_valid = busy = interrupt = 0.
  - Load responses arriving after reset still write the register.

Decomposition:
- Shared package rocc_accum_pkg holds:
  - funct enum: FN_WRITE, FN_READ, FN_LOAD, FN_ACCUM, FN_STORE, FN_CLEAR.
  - Memory cmd constants: M_XRD = 0, M_XWR = 1, MT_D = 3.
- One sub-module, accum_alu: combinational wrap/saturating adder parametrised by XLEN and SATURATE.

Test Plan:
- Write 5 to r2 then accum 7 with xd=1 -> response data 5; a subsequent read of r2 returns 12.
- Loads to r1 and r3 issued back-to-back with cache responses reversed (tag 3 data 0xAA, then tag 1 data 0xBB) -> both busy bits set, then each clears on its own response; r1 = 0xBB, r3 = 0xAA.
- Accum to r1 while r1 is load-pending -> cmd_ready low and no response until the load response; accum then applies to the loaded value.
- SATURATE=1: write 0x7FFF_FFFF_FFFF_FFF0 to r0, accum 0x100 -> r0 = 0x7FFF_FFFF_FFFF_FFFF. With SATURATE=0 the same sequence gives 0x8000_0000_0000_00F0.
- Store r2 (value 12) to address 0x1000 with mem_req_ready low for 3 cycles -> request held stable; issued with cmd = 1, data = 12, tag = 0x0A; the ack does not change the scoreboard.
- Assert reset during an outstanding load, and hold resp_ready low with xd=1 -> all outputs 0 immediately; registers read 0 after reset; clear-all stalls while any busy bit is set, then zeroes all registers.
